// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
//
// Keeps the current fetch word address, selects the next one from the
// sequential, branch, jump and return paths, and keeps a small
// return-address stack that jal pushes and ret pops.
//
// Ports:
//   i_clk        - clock; all state updates on the rising edge
//   i_rst_n      - asynchronous active-low reset
//   i_stall      - hold PC and return stack this cycle
//   i_beq/i_bne  - conditional branch decodes, qualified by i_zero
//   i_zero       - ALU zero flag for the current instruction
//   i_j/i_jal    - jump and jump-and-link decodes
//   i_ret        - return decode (jr $ra)
//   i_imm26      - instruction immediate; low 16 bits are the branch offset
//   i_jr_target  - register jump address used when the stack is empty
//   o_pc         - current fetch word address
//   o_pc_inc     - o_pc + 1 (wraps)
//   o_pcsrc      - redirect taken this cycle
//   o_target     - selected redirect address (branch target when no redirect)
//   o_ras_empty  - stack holds no entries
//   o_ras_full   - stack holds RAS_DEPTH entries
//   o_ras_ovf    - sticky: a push overwrote a valid entry; cleared by reset only
//
// Parameters: PC_W must be 26..30, RAS_DEPTH a power of two in 2..16.
module pc_sequencer #(
  parameter int              PC_W      = 30,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_beq,
  input  logic            i_bne,
  input  logic            i_zero,
  input  logic            i_j,
  input  logic            i_jal,
  input  logic            i_ret,
  input  logic [25:0]     i_imm26,
  input  logic [PC_W-1:0] i_jr_target,
  output logic [PC_W-1:0] o_pc,
  output logic [PC_W-1:0] o_pc_inc,
  output logic            o_pcsrc,
  output logic [PC_W-1:0] o_target,
  output logic            o_ras_empty,
  output logic            o_ras_full,
  output logic            o_ras_ovf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_reg;
  logic [PTR_W-1:0] ptr_reg;    // next slot to write; top of stack is ptr_reg - 1
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  branch_target;
  logic [PC_W-1:0]  jump_target;
  logic [PC_W-1:0]  ret_target;
  logic [PC_W-1:0]  ras_top;
  logic [PTR_W-1:0] top_idx;
  logic             branch_taken;
  logic             ras_empty;
  logic             ras_full;
  logic             pcsrc;
  logic [PC_W-1:0]  target;
  logic             push;
  logic             pop;

  assign pc_inc        = pc_reg + PC_W'(1);
  assign branch_target = pc_inc + {{(PC_W-16){i_imm26[15]}}, i_imm26[15:0]};
  assign branch_taken  = (i_beq & i_zero) | (i_bne & ~i_zero);

  // Jumps keep the region bits above the 26-bit field from the incremented PC;
  // with a 26-bit PC there are no region bits left.
  generate
    if (PC_W > 26) begin : g_jump_region
      assign jump_target = {pc_inc[PC_W-1:26], i_imm26};
    end else begin : g_jump_flat
      assign jump_target = i_imm26;
    end
  endgenerate

  assign ras_empty  = (count_reg == '0);
  assign ras_full   = (count_reg == CNT_MAX);
  assign top_idx    = ptr_reg - PTR_W'(1);
  assign ras_top    = ras_mem[top_idx];
  assign ret_target = ras_empty ? i_jr_target : ras_top;

  // Return beats jump/jal, which beat a taken branch. With no redirect the
  // branch target is still presented on o_target.
  always_comb begin
    pcsrc  = 1'b0;
    target = branch_target;
    if (i_ret) begin
      pcsrc  = 1'b1;
      target = ret_target;
    end else if (i_j || i_jal) begin
      pcsrc  = 1'b1;
      target = jump_target;
    end else if (branch_taken) begin
      pcsrc  = 1'b1;
    end
  end

  // ret suppresses a simultaneous jal push; a ret on an empty stack is a no-op.
  assign push = ~i_stall & i_jal & ~i_ret;
  assign pop  = ~i_stall & i_ret & ~ras_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_reg    <= RESET_PC;
      ptr_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      if (!i_stall) begin
        pc_reg <= pcsrc ? target : pc_inc;
      end
      if (pop) begin
        ptr_reg   <= ptr_reg - PTR_W'(1);
        count_reg <= count_reg - CNT_W'(1);
      end else if (push) begin
        // When full the write slot is the oldest entry, so the circular
        // pointer overwrites it and the count stays saturated.
        ptr_reg <= ptr_reg + PTR_W'(1);
        if (ras_full) begin
          ovf_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end
  end

  // Stack storage has no reset; an empty count makes stale entries invisible.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && push) begin
      ras_mem[ptr_reg] <= pc_inc;
    end
  end

  assign o_pc        = pc_reg;
  assign o_pc_inc    = pc_inc;
  assign o_pcsrc     = pcsrc;
  assign o_target    = target;
  assign o_ras_empty = ras_empty;
  assign o_ras_full  = ras_full;
  assign o_ras_ovf   = ovf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a
// queue-based reference model of the PC and return-address stack.
module tb_pc_sequencer;

  localparam int PC_W  = 30;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic            stall, beq, bne, zero, j, jal, ret;
  logic [25:0]     imm26;
  logic [PC_W-1:0] jr_target;
  logic [PC_W-1:0] pc, pc_inc, target;
  logic            pcsrc, ras_empty, ras_full, ras_ovf;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_q[$];
  logic            m_ovf;

  pc_sequencer #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_beq(beq), .i_bne(bne),
    .i_zero(zero), .i_j(j), .i_jal(jal), .i_ret(ret), .i_imm26(imm26),
    .i_jr_target(jr_target), .o_pc(pc), .o_pc_inc(pc_inc), .o_pcsrc(pcsrc),
    .o_target(target), .o_ras_empty(ras_empty), .o_ras_full(ras_full),
    .o_ras_ovf(ras_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc  = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // {pcsrc, target} from the redirect rules, using the model's PC and stack.
  function automatic logic [PC_W:0] model_redirect();
    logic [PC_W-1:0] inc, tgt;
    logic            taken, src;
    inc   = m_pc + 30'd1;
    taken = (beq && zero) || (bne && !zero);
    src   = ret || j || jal || taken;
    if (ret)             tgt = (m_q.size() != 0) ? m_q[$] : jr_target;
    else if (j || jal)   tgt = {inc[29:26], imm26};
    else                 tgt = inc + {{14{imm26[15]}}, imm26[15:0]};
    return {src, tgt};
  endfunction

  task automatic model_edge();
    logic [PC_W:0] r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (stall) return;
    r = model_redirect();
    if (ret) begin
      if (m_q.size() != 0) void'(m_q.pop_back());
    end else if (jal) begin
      m_q.push_back(m_pc + 30'd1);
      if (m_q.size() > DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1'b1;
      end
    end
    m_pc = r[PC_W] ? r[PC_W-1:0] : m_pc + 30'd1;
  endtask

  // Advance one clock, keeping the model in step; returns 1 ns after the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; beq = 0; bne = 0; zero = 0; j = 0; jal = 0; ret = 0;
    imm26 = '0; jr_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // Load an arbitrary PC through a return on an empty stack.
  task automatic set_pc_jr(input logic [PC_W-1:0] v);
    ret = 1; jr_target = v;
    tick();
    ret = 0; jr_target = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #3;
    model_reset();
    vectors++; if (pc !== 30'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 30'h0); end
    vectors++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", ras_empty); end
    vectors++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", ras_full); end
    vectors++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ras_ovf); end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++; if (pc !== PC_W'(i)) begin errors++; $display("FAIL seq_pc step %0d got %h want %h", i, pc, PC_W'(i)); end
      vectors++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL seq_empty step %0d got %b want 1", i, ras_empty); end
    end
    $display("test_reset done");
  endtask

  task automatic test_branch();
    set_pc_jr(30'h10);
    beq = 1; zero = 1; imm26 = 26'h000FFFE;
    #1;
    vectors++; if (target !== 30'h0F) begin errors++; $display("FAIL beq_target got %h want %h", target, 30'h0F); end
    vectors++; if (pcsrc !== 1'b1) begin errors++; $display("FAIL beq_pcsrc got %b want 1", pcsrc); end
    tick();
    vectors++; if (pc !== 30'h0F) begin errors++; $display("FAIL beq_taken_pc got %h want %h", pc, 30'h0F); end
    clear_inputs();
    set_pc_jr(30'h10);
    beq = 1; zero = 0; imm26 = 26'h000FFFE;
    #1;
    vectors++; if (pcsrc !== 1'b0) begin errors++; $display("FAIL beq_nt_pcsrc got %b want 0", pcsrc); end
    vectors++; if (target !== 30'h0F) begin errors++; $display("FAIL beq_nt_target got %h want %h", target, 30'h0F); end
    tick();
    vectors++; if (pc !== 30'h11) begin errors++; $display("FAIL beq_nt_pc got %h want %h", pc, 30'h11); end
    clear_inputs();
    bne = 1; zero = 0; imm26 = 26'h0000004;
    #1;
    vectors++; if (target !== 30'h16) begin errors++; $display("FAIL bne_target got %h want %h", target, 30'h16); end
    tick();
    vectors++; if (pc !== 30'h16) begin errors++; $display("FAIL bne_pc got %h want %h", pc, 30'h16); end
    clear_inputs();
    $display("test_branch done");
  endtask

  task automatic test_wrap();
    set_pc_jr(30'h3FFFFFFF);
    #1;
    vectors++; if (pc_inc !== 30'h0) begin errors++; $display("FAIL wrap_inc got %h want 0", pc_inc); end
    vectors++; if (pcsrc !== 1'b0) begin errors++; $display("FAIL wrap_pcsrc got %b want 0", pcsrc); end
    tick();
    vectors++; if (pc !== 30'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
    set_pc_jr(30'h20000005);
    j = 1; imm26 = 26'h123;
    #1;
    vectors++; if (target !== 30'h20000123) begin errors++; $display("FAIL jump_target got %h want %h", target, 30'h20000123); end
    tick();
    vectors++; if (pc !== 30'h20000123) begin errors++; $display("FAIL jump_pc got %h want %h", pc, 30'h20000123); end
    clear_inputs();
    $display("test_wrap done");
  endtask

  task automatic test_ras_overflow();
    logic [PC_W-1:0] exp_t [5];
    exp_t = '{30'h51, 30'h41, 30'h31, 30'h21, 30'h99};
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      j = 1; imm26 = 26'(k * 16);
      tick();
      j = 0; jal = 1; imm26 = 26'h200;
      tick();
      jal = 0;
    end
    vectors++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", ras_full); end
    vectors++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ras_ovf); end
    ret = 1; jr_target = 30'h99;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (target !== exp_t[k]) begin errors++; $display("FAIL ret_target %0d got %h want %h", k, target, exp_t[k]); end
      if (k == 4) begin
        vectors++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b want 1", ras_empty); end
      end
      tick();
    end
    vectors++; if (pc !== 30'h99) begin errors++; $display("FAIL ret_final_pc got %h want %h", pc, 30'h99); end
    vectors++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ras_ovf); end
    clear_inputs();
    $display("test_ras_overflow done");
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    stall = 1; jal = 1; imm26 = 26'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (pc !== 30'h1) begin errors++; $display("FAIL stall_pc %0d got %h want 1", i, pc); end
      vectors++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL stall_count %0d got %b want 1", i, ras_empty); end
    end
    clear_inputs();
    tick();
    tick();
    // Asynchronous reset between edges, with a stalled jump pending.
    stall = 1; j = 1; imm26 = 26'h555;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    vectors++; if (pc !== 30'h0) begin errors++; $display("FAIL async_rst_pc got %h want 0", pc); end
    @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1;
    tick();
    vectors++; if (pc !== 30'h1) begin errors++; $display("FAIL post_rst_pc got %h want 1", pc); end
    $display("test_stall done");
  endtask

  task automatic test_ret_jal();
    do_reset();
    j = 1; imm26 = 26'h76;
    tick();
    j = 0; jal = 1; imm26 = 26'h400;
    tick();
    jal = 0; ret = 1; jal = 1; jr_target = 30'h1234;
    #1;
    vectors++; if (target !== 30'h77) begin errors++; $display("FAIL retjal_target got %h want %h", target, 30'h77); end
    tick();
    vectors++; if (pc !== 30'h77) begin errors++; $display("FAIL retjal_pc got %h want %h", pc, 30'h77); end
    vectors++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL retjal_empty got %b want 1", ras_empty); end
    clear_inputs();
    $display("test_ret_jal done");
  endtask

  task automatic test_random();
    logic [PC_W:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 8) == 0;
      ret   = ($urandom % 5) == 0;
      jal   = ($urandom % 4) == 0;
      j     = ($urandom % 8) == 0;
      beq   = ($urandom % 4) == 0;
      bne   = ($urandom % 4) == 0;
      zero  = $urandom % 2;
      imm26 = 26'($urandom);
      jr_target = 30'($urandom);
      #1;
      r = model_redirect();
      vectors++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
      vectors++; if (pc_inc !== m_pc + 30'd1) begin errors++; $display("FAIL rnd_inc cyc %0d got %h want %h", i, pc_inc, m_pc + 30'd1); end
      vectors++; if (pcsrc !== r[PC_W]) begin errors++; $display("FAIL rnd_pcsrc cyc %0d got %b want %b", i, pcsrc, r[PC_W]); end
      vectors++; if (target !== r[PC_W-1:0]) begin errors++; $display("FAIL rnd_target cyc %0d got %h want %h", i, target, r[PC_W-1:0]); end
      vectors++; if (ras_empty !== (m_q.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc %0d got %b want %b", i, ras_empty, m_q.size() == 0); end
      vectors++; if (ras_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc %0d got %b want %b", i, ras_full, m_q.size() == DEPTH); end
      vectors++; if (ras_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %b want %b", i, ras_ovf, m_ovf); end
      tick();
    end
    clear_inputs();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_branch();
    test_wrap();
    test_ras_overflow();
    test_stall();
    test_ret_jal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
